vga_tile_compositor: RTL and testbench

//  Parametrised multi-channel pixel compositor for the VGA output path. Takes CH_NUM
//  24-bit pixel sources and the current raster position, and emits one composited

---
 rtl/vga_pkg.sv | 35 +++
 rtl/vga_res_table.sv | 27 ++
 rtl/vga_tile_compositor.sv | 219 +++++++++++++++++++++
 tb/tb_vga_tile_compositor.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA definitions: resolution codes, active sizes, layouts, pixel helpers.
package vga_pkg;

    typedef enum logic [3:0] {
        RES_640X480  = 4'd0,
        RES_800X600  = 4'd1,
        RES_1024X768 = 4'd2,
        RES_1280X720 = 4'd3
    } res_e;

    localparam int H_640  = 640;
    localparam int V_480  = 480;
    localparam int H_800  = 800;
    localparam int V_600  = 600;
    localparam int H_1024 = 1024;
    localparam int V_768  = 768;
    localparam int H_1280 = 1280;
    localparam int V_720  = 720;

    typedef enum logic [1:0] {
        LAYOUT_FULL = 2'd0,
        LAYOUT_2X1  = 2'd1,
        LAYOUT_2X2  = 2'd2,
        LAYOUT_4X4  = 2'd3
    } layout_e;

    // px_ch value meaning "no channel shown" (black, border or out of range)
    localparam logic [3:0] CH_NONE = 4'hF;

    // Top nibble of each colour component
    function automatic logic [11:0] to_12bit(input logic [23:0] p);
        return {p[23:20], p[15:12], p[7:4]};
    endfunction

endpackage

// File: rtl/vga_res_table.sv
// Resolution code -> active width/height lookup; flags codes we cannot drive.
module vga_res_table
    import vga_pkg::*;
#(
    parameter int COORD_W = 11
) (
    input  logic [3:0]         resolution,
    output logic [COORD_W-1:0] h_active,
    output logic [COORD_W-1:0] v_active,
    output logic               supported
);

    // Pure decode; unsupported codes report 640x480 but callers must ignore them
    always_comb begin
        h_active  = COORD_W'(H_640);
        v_active  = COORD_W'(V_480);
        supported = 1'b1;
        case (resolution)
            RES_640X480:  begin h_active = COORD_W'(H_640);  v_active = COORD_W'(V_480); end
            RES_800X600:  begin h_active = COORD_W'(H_800);  v_active = COORD_W'(V_600); end
            RES_1024X768: begin h_active = COORD_W'(H_1024); v_active = COORD_W'(V_768); end
            RES_1280X720: begin h_active = COORD_W'(H_1280); v_active = COORD_W'(V_720); end
            default:      supported = 1'b0;
        endcase
    end

endmodule

// File: rtl/vga_tile_compositor.sv
// Multi-channel tile compositor: picks one channel pixel per raster position,
// overlays optional tile borders, emits 24/12-bit pixel two cycles later.
module vga_tile_compositor
    import vga_pkg::*;
#(
    parameter int CH_NUM  = 4,
    parameter int PX_W    = 24,
    parameter int COORD_W = 11
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CH_NUM*PX_W-1:0]   ch_data,
    input  logic [COORD_W-1:0]       px_h,
    input  logic [COORD_W-1:0]       px_v,
    input  logic                     px_valid,
    input  logic                     frame_start,
    input  logic [3:0]               resolution,
    input  logic [1:0]               layout,
    input  logic [3:0]               sel_ch,
    input  logic                     border_en,
    input  logic [23:0]              border_color,
    output logic [23:0]              px_24bit_data,
    output logic [11:0]              px_12bit_data,
    output logic                     px_out_valid,
    output logic [3:0]               px_ch,
    output logic                     cfg_err
);

    localparam int STAGES = 2;

    // ---------------- active configuration ----------------
    logic [COORD_W-1:0]      tbl_w, tbl_h;
    logic                    tbl_sup;
    logic                    latch;

    layout_e                 layout_q, layout_d;
    logic [3:0]              sel_ch_q, sel_ch_d;
    logic                    border_en_q, border_en_d;
    logic [23:0]             border_color_q, border_color_d;
    logic [COORD_W-1:0]      w_q, w_d, h_q, h_d;
    logic [2:0][COORD_W-1:0] hs_q, hs_d, vs_q, vs_d;   // W/4, W/2, 3W/4 (same on V)
    logic                    cfg_err_q, cfg_err_d;

    vga_res_table #(.COORD_W(COORD_W)) u_res_table (
        .resolution (resolution),
        .h_active   (tbl_w),
        .v_active   (tbl_h),
        .supported  (tbl_sup)
    );

    // Next config: the pixel carrying frame_start already sees the new values,
    // so S1 decodes against the *_d copies, which equal *_q outside the latch
    always_comb begin
        latch          = frame_start & px_valid;
        layout_d       = layout_q;
        sel_ch_d       = sel_ch_q;
        border_en_d    = border_en_q;
        border_color_d = border_color_q;
        w_d            = w_q;
        h_d            = h_q;
        hs_d           = hs_q;
        vs_d           = vs_q;
        if (latch) begin
            layout_d       = layout_e'(layout);
            sel_ch_d       = sel_ch;
            border_en_d    = border_en;
            border_color_d = border_color;
            if (tbl_sup) begin
                w_d   = tbl_w;
                h_d   = tbl_h;
                hs_d[0] = tbl_w >> 2;
                hs_d[1] = tbl_w >> 1;
                hs_d[2] = (tbl_w >> 1) + (tbl_w >> 2);
                vs_d[0] = tbl_h >> 2;
                vs_d[1] = tbl_h >> 1;
                vs_d[2] = (tbl_h >> 1) + (tbl_h >> 2);
            end
        end
        cfg_err_d = latch & ~tbl_sup;
    end

    // Config register, reset to 640x480 full-screen channel 0
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            layout_q       <= LAYOUT_FULL;
            sel_ch_q       <= '0;
            border_en_q    <= 1'b0;
            border_color_q <= '0;
            w_q            <= COORD_W'(H_640);
            h_q            <= COORD_W'(V_480);
            hs_q           <= {COORD_W'(480), COORD_W'(320), COORD_W'(160)};
            vs_q           <= {COORD_W'(360), COORD_W'(240), COORD_W'(120)};
            cfg_err_q      <= 1'b0;
        end else begin
            layout_q       <= layout_d;
            sel_ch_q       <= sel_ch_d;
            border_en_q    <= border_en_d;
            border_color_q <= border_color_d;
            w_q            <= w_d;
            h_q            <= h_d;
            hs_q           <= hs_d;
            vs_q           <= vs_d;
            cfg_err_q      <= cfg_err_d;
        end
    end

    // ---------------- stage 1: geometry decode ----------------
    logic [1:0]             col, row;
    logic                   split_hit;
    logic [3:0]             idx_d, idx_q;
    logic                   in_range_d, in_range_q;
    logic                   border_d, border_q;
    logic [CH_NUM*PX_W-1:0] data_q;
    logic [STAGES:1]        vld_pipe_q;

    // Tile column/row by comparing against registered split lines
    always_comb begin
        col       = '0;
        row       = '0;
        idx_d     = sel_ch_d;
        split_hit = 1'b0;
        case (layout_d)
            LAYOUT_FULL: idx_d = sel_ch_d;
            LAYOUT_2X1: begin
                col       = {1'b0, (px_h >= hs_d[1])};
                idx_d     = {2'b00, col};
                split_hit = (px_h == hs_d[1]);
            end
            LAYOUT_2X2: begin
                col       = {1'b0, (px_h >= hs_d[1])};
                row       = {1'b0, (px_v >= vs_d[1])};
                idx_d     = {2'b00, row[0], col[0]};
                split_hit = (px_h == hs_d[1]) || (px_v == vs_d[1]);
            end
            default: begin
                col       = 2'(px_h >= hs_d[0]) + 2'(px_h >= hs_d[1]) + 2'(px_h >= hs_d[2]);
                row       = 2'(px_v >= vs_d[0]) + 2'(px_v >= vs_d[1]) + 2'(px_v >= vs_d[2]);
                idx_d     = {row, col};
                split_hit = (px_h == hs_d[0]) || (px_h == hs_d[1]) || (px_h == hs_d[2]) ||
                            (px_v == vs_d[0]) || (px_v == vs_d[1]) || (px_v == vs_d[2]);
            end
        endcase
        in_range_d = (px_h < w_d) && (px_v < h_d);
        border_d   = border_en_d && (layout_d != LAYOUT_FULL) &&
                     (split_hit || (px_h == w_d - COORD_W'(1)) || (px_v == h_d - COORD_W'(1)));
    end

    // S1 register; advances every cycle regardless of px_valid
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q      <= '0;
            in_range_q <= 1'b0;
            border_q   <= 1'b0;
            data_q     <= '0;
            vld_pipe_q <= '0;
        end else begin
            idx_q      <= idx_d;
            in_range_q <= in_range_d;
            border_q   <= border_d;
            data_q     <= ch_data;
            vld_pipe_q <= {vld_pipe_q[STAGES-1:1], px_valid};
        end
    end

    // ---------------- stage 2: pixel select ----------------
    logic [PX_W-1:0] ch_pix;
    logic            ch_ok;
    logic [23:0]     pix_d, pix_q;
    logic [11:0]     p12_d, p12_q;
    logic [3:0]      px_ch_d, px_ch_q;

    // Priority mux; outputs hold when the S1 slot carries no pixel
    always_comb begin
        ch_pix = '0;
        for (int k = 0; k < CH_NUM; k++) begin
            if (idx_q == 4'(k)) ch_pix = data_q[k*PX_W +: PX_W];
        end
        ch_ok   = ({1'b0, idx_q} < 5'(CH_NUM));
        pix_d   = pix_q;
        p12_d   = p12_q;
        px_ch_d = px_ch_q;
        if (vld_pipe_q[1]) begin
            if (!in_range_q) begin
                pix_d   = '0;
                px_ch_d = CH_NONE;
            end else if (border_q) begin
                pix_d   = border_color_q;
                px_ch_d = CH_NONE;
            end else if (!ch_ok) begin
                pix_d   = '0;
                px_ch_d = CH_NONE;
            end else begin
                pix_d   = 24'(ch_pix);
                px_ch_d = idx_q;
            end
            p12_d = to_12bit(pix_d);
        end
    end

    // S2 output register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix_q   <= '0;
            p12_q   <= '0;
            px_ch_q <= CH_NONE;
        end else begin
            pix_q   <= pix_d;
            p12_q   <= p12_d;
            px_ch_q <= px_ch_d;
        end
    end

    assign px_24bit_data = pix_q;
    assign px_12bit_data = p12_q;
    assign px_ch         = px_ch_q;
    assign px_out_valid  = vld_pipe_q[STAGES];
    assign cfg_err       = cfg_err_q;

endmodule

// File: tb/tb_vga_tile_compositor.sv
// Scoreboard bench: driver pushes model results, monitor pops on px_out_valid.
module tb_vga_tile_compositor;

    localparam int CH_NUM  = 4;
    localparam int PX_W    = 24;
    localparam int COORD_W = 11;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [CH_NUM*PX_W-1:0] ch_data = '0;
    logic [COORD_W-1:0]     px_h = '0, px_v = '0;
    logic                   px_valid = 1'b0, frame_start = 1'b0;
    logic [3:0]             resolution = '0;
    logic [1:0]             layout = '0;
    logic [3:0]             sel_ch = '0;
    logic                   border_en = 1'b0;
    logic [23:0]            border_color = '0;
    logic [23:0]            px_24bit_data;
    logic [11:0]            px_12bit_data;
    logic                   px_out_valid;
    logic [3:0]             px_ch;
    logic                   cfg_err;

    vga_tile_compositor #(.CH_NUM(CH_NUM), .PX_W(PX_W), .COORD_W(COORD_W)) dut (
        .clk(clk), .rst(rst), .ch_data(ch_data), .px_h(px_h), .px_v(px_v),
        .px_valid(px_valid), .frame_start(frame_start), .resolution(resolution),
        .layout(layout), .sel_ch(sel_ch), .border_en(border_en), .border_color(border_color),
        .px_24bit_data(px_24bit_data), .px_12bit_data(px_12bit_data),
        .px_out_valid(px_out_valid), .px_ch(px_ch), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int res; int lay; int sel; bit ben; logic [23:0] col; } cfg_t;
    typedef struct { int due; logic [23:0] p; logic [3:0] ch; } exp_t;

    cfg_t        mc;
    exp_t        q[$];
    exp_t        mon_e;
    logic [23:0] chv [CH_NUM];
    bit          rand_ch = 1'b1;
    bit          prev_bad = 1'b0;
    logic [23:0] last_p = '0;
    logic [3:0]  last_ch = 4'hF;

    function automatic int res_w(input int r);
        case (r) 0: return 640; 1: return 800; 2: return 1024; default: return 1280; endcase
    endfunction
    function automatic int res_h(input int r);
        case (r) 0: return 480; 1: return 600; 2: return 768; default: return 720; endcase
    endfunction
    function automatic logic [11:0] nib(input logic [23:0] p);
        logic [11:0] r;
        r[11:8] = p[23:20]; r[7:4] = p[15:12]; r[3:0] = p[7:4];
        return r;
    endfunction

    // Reference: tile size by division, borders as multiples of the tile size
    function automatic void model(input int h, input int v, output logic [23:0] p, output logic [3:0] ch);
        int W, H, cols, rows, tw, th, col, row, idx;
        bit bord;
        W = res_w(mc.res); H = res_h(mc.res);
        case (mc.lay)
            0: begin cols = 1; rows = 1; end
            1: begin cols = 2; rows = 1; end
            2: begin cols = 2; rows = 2; end
            default: begin cols = 4; rows = 4; end
        endcase
        p = '0; ch = 4'hF;
        if (h >= W || v >= H) return;
        tw = W / cols; th = H / rows;
        col = h / tw; row = v / th;
        bord = mc.ben && mc.lay != 0 &&
               ((h % tw == 0 && h != 0) || (v % th == 0 && v != 0) || h == W-1 || v == H-1);
        if (bord) begin p = mc.col; return; end
        idx = (mc.lay == 0) ? mc.sel : row * cols + col;
        if (idx >= CH_NUM) return;
        p = chv[idx]; ch = 4'(idx);
    endfunction

    function automatic cfg_t cfg_default();
        cfg_t c;
        c.res = 0; c.lay = 0; c.sel = 0; c.ben = 1'b0; c.col = '0;
        return c;
    endfunction

    // One cycle of stimulus; also checks the cfg_err pulse of the previous latch
    task automatic drive(input int h, input int v, input bit val, input bit fs);
        exp_t e;
        @(negedge clk);
        total++;
        if (cfg_err !== prev_bad) begin
            bad++;
            $display("FAIL cfg_err cyc=%0d got %b want %b", cyc, cfg_err, prev_bad);
        end
        px_h = COORD_W'(h); px_v = COORD_W'(v);
        px_valid = val; frame_start = fs;
        for (int k = 0; k < CH_NUM; k++) begin
            if (rand_ch) chv[k] = 24'($urandom);
            ch_data[k*PX_W +: PX_W] = chv[k];
        end
        prev_bad = 1'b0;
        if (val && fs) begin
            if (resolution < 4) mc.res = int'(resolution);
            else prev_bad = 1'b1;
            mc.lay = int'(layout); mc.sel = int'(sel_ch);
            mc.ben = border_en; mc.col = border_color;
        end
        if (val) begin
            model(h, v, e.p, e.ch);
            e.due = cyc + 2;
            q.push_back(e);
        end
    endtask

    task automatic frame(input int r, input int lay, input int sel, input bit be, input logic [23:0] bc);
        resolution = 4'(r); layout = 2'(lay); sel_ch = 4'(sel);
        border_en = be; border_color = bc;
        drive(0, 0, 1'b1, 1'b1);
    endtask

    task automatic check_reset_vals(input string tag);
        total++;
        if (px_24bit_data !== 24'h0 || px_12bit_data !== 12'h0 || px_out_valid !== 1'b0 ||
            px_ch !== 4'hF || cfg_err !== 1'b0) begin
            bad++;
            $display("FAIL %s got %h/%h/%b/%h/%b want 000000/000/0/f/0", tag,
                     px_24bit_data, px_12bit_data, px_out_valid, px_ch, cfg_err);
        end
    endtask

    task automatic model_reset();
        q.delete();
        mc = cfg_default();
        last_p = '0; last_ch = 4'hF; prev_bad = 1'b0;
        px_valid = 1'b0; frame_start = 1'b0;
    endtask

    // Monitor: pop on valid, otherwise outputs must hold the last pixel
    always @(negedge clk) begin
        if (rst) begin
            if (px_out_valid) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_valid cyc=%0d got %h", cyc, px_24bit_data);
                end else begin
                    mon_e = q.pop_front();
                    if (cyc != mon_e.due || px_24bit_data !== mon_e.p ||
                        px_12bit_data !== nib(mon_e.p) || px_ch !== mon_e.ch) begin
                        bad++;
                        $display("FAIL pixel cyc=%0d due=%0d got %h/%h/%h want %h/%h/%h", cyc, mon_e.due,
                                 px_24bit_data, px_12bit_data, px_ch, mon_e.p, nib(mon_e.p), mon_e.ch);
                    end
                    last_p = mon_e.p; last_ch = mon_e.ch;
                end
            end else begin
                total++;
                if (px_24bit_data !== last_p || px_ch !== last_ch) begin
                    bad++;
                    $display("FAIL hold cyc=%0d got %h/%h want %h/%h", cyc, px_24bit_data, px_ch, last_p, last_ch);
                end
            end
        end
    end

    initial begin
        int r, h, v, W, H, tw, th;
        mc = cfg_default();
        for (int k = 0; k < CH_NUM; k++) chv[k] = '0;

        // 1. reset for 3 cycles, then valid pattern with default config
        #2 rst = 1'b0;
        #1 check_reset_vals("reset_async");
        repeat (3) begin @(negedge clk); check_reset_vals("reset_hold"); end
        model_reset();
        rst = 1'b1;
        drive(5, 5, 1, 0); drive(6, 5, 0, 0); drive(7, 5, 1, 0); drive(8, 5, 1, 0);
        drive(9, 5, 0, 0); drive(10, 5, 0, 0); drive(11, 5, 1, 0);

        // 2. 2x2 at 640x480 with fixed colours
        rand_ch = 1'b0;
        chv[0] = 24'hFF0000; chv[1] = 24'h00FF00; chv[2] = 24'h0000FF; chv[3] = 24'hFFFFFF;
        frame(0, 2, 0, 0, 24'h0);
        drive(100, 100, 1, 0); drive(400, 100, 1, 0); drive(100, 300, 1, 0); drive(639, 479, 1, 0);
        rand_ch = 1'b1;

        // 3. 4x4 at 1024x768
        frame(2, 3, 0, 0, 24'h0);
        drive(300, 10, 1, 0); drive(10, 200, 1, 0);

        // 4. borders at 800x600 2x2
        frame(1, 2, 0, 1, 24'h123456);
        drive(400, 50, 1, 0); drive(399, 50, 1, 0); drive(799, 10, 1, 0); drive(20, 300, 1, 0);

        // 5. mid-frame config change ignored; bad resolution keeps W,H
        frame(0, 0, 1, 0, 24'h0);
        drive(50, 99, 1, 0);
        layout = 2'd2; sel_ch = 4'd3; resolution = 4'd2;
        drive(50, 100, 1, 0); drive(500, 400, 1, 0);
        frame(9, 2, 0, 0, 24'h0);
        drive(630, 470, 1, 0); drive(700, 100, 1, 0); drive(100, 479, 1, 0);

        // 6. out of range, then async reset mid-line
        drive(700, 10, 1, 0); drive(600, 10, 1, 0); drive(601, 10, 1, 0);
        @(posedge clk); #3 rst = 1'b0;
        #1 check_reset_vals("reset_midline");
        model_reset();
        @(negedge clk); check_reset_vals("reset_midline_hold");
        rst = 1'b1;
        frame(3, 1, 0, 1, 24'hABCDEF);
        drive(640, 5, 1, 0); drive(639, 5, 1, 0); drive(1279, 5, 1, 0); drive(1280, 5, 1, 0);

        // Randomised frames
        for (int f = 0; f < 10; f++) begin
            r = ($urandom_range(0, 4) == 4) ? int'($urandom_range(4, 15)) : int'($urandom_range(0, 3));
            frame(r, int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                  bit'($urandom_range(0, 1)), 24'($urandom));
            for (int i = 0; i < 80; i++) begin
                W = res_w(mc.res); H = res_h(mc.res); tw = W / 4; th = H / 4;
                case ($urandom_range(0, 4))
                    0: h = int'($urandom_range(0, W + 50));
                    1: h = tw * int'($urandom_range(1, 3));
                    2: h = tw * int'($urandom_range(1, 3)) - 1;
                    3: h = W - 1;
                    default: h = W / 2 + int'($urandom_range(0, 1));
                endcase
                case ($urandom_range(0, 4))
                    0: v = int'($urandom_range(0, H + 50));
                    1: v = th * int'($urandom_range(1, 3));
                    2: v = th * int'($urandom_range(1, 3)) - 1;
                    3: v = H - 1;
                    default: v = int'($urandom_range(0, H - 1));
                endcase
                if (i == 40) begin
                    layout = 2'($urandom); sel_ch = 4'($urandom); border_en = ~border_en;
                end
                drive(h, v, $urandom_range(0, 3) != 0, 1'b0);
            end
        end

        // Drain
        repeat (4) drive(0, 0, 1'b0, 1'b0);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
